decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL take parameter IW, default 8, as the instruction width in bits.
REQ-002 The block SHALL take parameter OPW, default 4, as the opcode width; opcode = instr[IW-1:IW-OPW]; operand = instr[IW-OPW-1:0].
REQ-003 The block SHALL take parameter CNTW, default 16, as the width of the delivered-instruction counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: discards all buffered instructions.
REQ-007 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and instr (input, IW bits) forming the upstream handshake.
REQ-008 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit) forming the downstream handshake.
REQ-009 The block SHALL have port ctrl, output, 6 bits: one-hot {out, inp, bitand, sub, add, load}.
REQ-010 The block SHALL have port operand, output, IW-OPW bits: the operand field of the presented instruction.
REQ-011 The block SHALL have port illegal, output, 1 bit: the presented instruction has an undefined opcode.
REQ-012 The block SHALL have port trap (output, 1 bit) and port trap_clr (input, 1 bit).
REQ-013 The block SHALL have port dec_count, output, CNTW bits: count of instructions delivered downstream.

Function
REQ-014 Opcode map SHALL be: 0 load, 1 add, 2 sub, 3 bitand, 4 inp, 5 out; every other opcode is illegal with ctrl = 0.
REQ-015 Transfer SHALL occur on in_valid & in_ready (accept) and on out_valid & out_ready (deliver).
REQ-016 Buffering SHALL be a 2-entry skid: an output register plus one skid register; decode happens before the register.
REQ-017 Latency SHALL be exactly 1 cycle: an instruction accepted in cycle N appears with out_valid = 1 in cycle N+1 when the output register is empty or delivering.
REQ-018 in_ready SHALL be registered and equal to "skid register empty", with no combinational path from out_ready.
REQ-019 When the output register holds data and out_ready = 0, an accepted instruction SHALL go into the skid register; the next cycle in_ready = 0.
REQ-020 On deliver with the skid register full, skid contents SHALL move to the output register in the same edge, and in_ready SHALL return to 1.
REQ-021 Simultaneous accept and deliver with the skid register empty SHALL load the new instruction directly into the output register, sustaining 1 instruction per cycle.
REQ-022 ctrl, operand and illegal SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-023 flush SHALL clear both entries the next edge (out_valid = 0, in_ready = 1); an instruction offered in the flush cycle is not accepted; flush has priority over accept and deliver.
REQ-024 dec_count SHALL increment by 1 per deliver and wrap from 2^CNTW-1 to 0; flush SHALL NOT change it.
REQ-025 trap SHALL be 0 whenever the configuration macro is undefined.

Reset
REQ-026 While rst_n = 0 at a clock edge, the block SHALL set out_valid = 0, ctrl = 0, operand = 0, illegal = 0, trap = 0, dec_count = 0, skid empty and in_ready = 0.
REQ-027 in_ready SHALL rise to 1 on the first edge with rst_n = 1.
REQ-028 Reset mid-transfer SHALL drop all buffered instructions without delivering them.

Configuration
REQ-029 With macro DECODE_STAGE_ILLEGAL_TRAP_EN defined, an accepted illegal instruction SHALL NOT be forwarded; trap SHALL set at the next edge, be sticky, and force in_ready = 0 until trap_clr = 1; already-buffered legal instructions SHALL still drain.
REQ-030 With the macro defined, trap_clr SHALL clear trap on the next edge, and in_ready SHALL reassert on the following edge if the skid register is empty; flush SHALL NOT clear trap.
REQ-031 With the macro undefined, illegal instructions SHALL be forwarded with ctrl = 0 and illegal = 1, and trap_clr SHALL be ignored.

Verification
REQ-032 Reset then stream 0x00,0x10,0x20,0x30,0x40,0x50 with out_ready = 1 -> ctrl = 000001,000010,000100,001000,010000,100000 on consecutive cycles, dec_count = 6.
REQ-033 Hold out_ready = 0 and offer 0x13, 0x27, 0x3F -> first two accepted, in_ready = 0 after the second; release out_ready -> delivered in order with operand 3, 7, then 0x3F accepted.
REQ-034 Offer 0xA5 -> macro undefined: out_valid with ctrl = 0, illegal = 1, operand = 5; macro defined: trap = 1, nothing delivered, in_ready = 0 until trap_clr.
REQ-035 Fill both entries, assert flush with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, dec_count unchanged.
REQ-036 Preload dec_count to 0xFFFF via 65535 delivers, deliver one more -> dec_count = 0x0000.
REQ-037 Assert rst_n = 0 with both entries full -> next cycle out_valid = 0, dec_count = 0, in_ready = 0; in_ready = 1 one cycle after release.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: opcode decode in front of a 2-entry skid buffer (output register plus skid register).
// Define DECODE_STAGE_ILLEGAL_TRAP_EN to make an accepted illegal opcode raise a sticky trap instead of being forwarded.
module decode_stage #(
  parameter int IW   = 8,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        ctrl,
  output logic [IW-OPW-1:0] operand,
  output logic              illegal,
  output logic              trap,
  input  logic              trap_clr,
  output logic [CNTW-1:0]   dec_count
);

  localparam int OW = IW - OPW;

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // in_ready is a register ("skid empty and no trap"), so it never depends on out_ready.

  logic [OPW-1:0] opcode;
  logic [5:0]     dec_ctrl;
  logic           dec_illegal;

  assign opcode = instr[IW-1:OW];

  always_comb begin
    dec_ctrl    = 6'b000000;
    dec_illegal = 1'b0;
    case (int'(opcode))
      0:       dec_ctrl = 6'b000001;
      1:       dec_ctrl = 6'b000010;
      2:       dec_ctrl = 6'b000100;
      3:       dec_ctrl = 6'b001000;
      4:       dec_ctrl = 6'b010000;
      5:       dec_ctrl = 6'b100000;
      default: dec_illegal = 1'b1;
    endcase
  end

  logic          skid_valid;
  logic [5:0]    skid_ctrl;
  logic [OW-1:0] skid_operand;
  logic          skid_illegal;

  logic accept, deliver, out_free, forward, trap_set, trap_block, skid_valid_nx;

  assign accept   = in_valid & in_ready & ~flush;
  assign deliver  = out_valid & out_ready & ~flush;
  assign out_free = ~out_valid | out_ready;

`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
  assign trap_set   = accept & dec_illegal;
  assign forward    = accept & ~dec_illegal;
  // Current trap (not next) so in_ready returns one edge after trap clears.
  assign trap_block = trap | trap_set;

  always_ff @(posedge clk) begin
    if (!rst_n)        trap <= 1'b0;
    else if (trap_set) trap <= 1'b1;
    else if (trap_clr) trap <= 1'b0;
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap_set        = 1'b0;
  assign forward         = accept;
  assign trap_block      = trap_set;
  assign trap            = 1'b0;
`endif

  always_comb begin
    skid_valid_nx = 1'b0;
    if (!flush && !out_free)
      skid_valid_nx = skid_valid | forward;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      ctrl         <= '0;
      operand      <= '0;
      illegal      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_ctrl    <= '0;
      skid_operand <= '0;
      skid_illegal <= 1'b0;
      in_ready     <= 1'b0;
      dec_count    <= '0;
    end else begin
      in_ready <= ~skid_valid_nx & ~trap_block;
      if (deliver)
        dec_count <= dec_count + CNTW'(1);
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (out_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          ctrl       <= skid_ctrl;
          operand    <= skid_operand;
          illegal    <= skid_illegal;
          skid_valid <= 1'b0;
        end else if (forward) begin
          out_valid <= 1'b1;
          ctrl      <= dec_ctrl;
          operand   <= instr[OW-1:0];
          illegal   <= dec_illegal;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (forward) begin
        skid_valid   <= 1'b1;
        skid_ctrl    <= dec_ctrl;
        skid_operand <= instr[OW-1:0];
        skid_illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table for decode/streaming plus directed stall, flush, trap, reset and wrap sequences.
module tb_decode_stage;

  localparam int W = 11;  // {illegal, ctrl[5:0], operand[3:0]}

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] instr;
  logic [5:0] ctrl;
  logic [3:0] operand;
  logic       illegal, trap, trap_clr;
  logic [15:0] dec_count;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl(ctrl), .operand(operand), .illegal(illegal),
    .trap(trap), .trap_clr(trap_clr), .dec_count(dec_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic [15:0] exp_cnt = 16'd0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] instr;
    logic [5:0] ctrl;
    logic       ill;
    logic [3:0] opnd;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [7:0] ins);
    logic [5:0] c;
    logic       il;
    c  = 6'b000000;
    il = 1'b0;
    case (ins[7:4])
      4'd0:    c = 6'b000001;
      4'd1:    c = 6'b000010;
      4'd2:    c = 6'b000100;
      4'd3:    c = 6'b001000;
      4'd4:    c = 6'b010000;
      4'd5:    c = 6'b100000;
      default: il = 1'b1;
    endcase
    return {il, c, ins[3:0]};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    out_ready = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].ctrl);
      check($sformatf("vec%0d_operand", i), operand, vecs[i].opnd);
      check($sformatf("vec%0d_illegal", i), illegal, vecs[i].ill);
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", out_valid, 0);
  endtask

  // scoreboard: predicts deliveries and dec_count from the handshake seen before each edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] m;
    if (mon_en) begin
      check("dec_count_track", dec_count, exp_cnt);
      if (!rst_n) begin
        exp_q.delete();
        exp_cnt = 16'd0;
      end else if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_unexpected: got 0x%0h expected nothing at %0t", {illegal, ctrl, operand}, $time);
          end else begin
            e = exp_q.pop_front();
            if ({illegal, ctrl, operand} !== e) begin
              errors++;
              $display("FAIL deliver_data: got 0x%0h expected 0x%0h at %0t", {illegal, ctrl, operand}, e, $time);
            end
          end
          exp_cnt = exp_cnt + 16'd1;
        end
        if (in_valid && in_ready) begin
          m = model(instr);
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
          if (!m[W-1]) exp_q.push_back(m);
`else
          exp_q.push_back(m);
`endif
        end
      end
    end
  end

  initial begin
    vecs[0] = '{8'h00, 6'b000001, 1'b0, 4'h0};
    vecs[1] = '{8'h10, 6'b000010, 1'b0, 4'h0};
    vecs[2] = '{8'h20, 6'b000100, 1'b0, 4'h0};
    vecs[3] = '{8'h30, 6'b001000, 1'b0, 4'h0};
    vecs[4] = '{8'h40, 6'b010000, 1'b0, 4'h0};
    vecs[5] = '{8'h50, 6'b100000, 1'b0, 4'h0};
    vecs[6] = '{8'h0F, 6'b000001, 1'b0, 4'hF};
    vecs[7] = '{8'h1A, 6'b000010, 1'b0, 4'hA};
    vecs[8] = '{8'h36, 6'b001000, 1'b0, 4'h6};
    vecs[9] = '{8'h59, 6'b100000, 1'b0, 4'h9};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 8'h00; trap_clr = 1'b0;
    repeat (2) step();
    mon_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_operand", operand, 0);
    check("rst_illegal", illegal, 0);
    check("rst_trap", trap, 0);
    check("rst_dec_count", dec_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("rst_release_in_ready", in_ready, 1);

    // opcode stream at one instruction per cycle
    run_vectors(0, 5);
    check("stream_count6", dec_count, 16'd6);
    run_vectors(6, 9);

    // stall with skid fill, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; instr = 8'h13;
    step();
    check("stall_first_valid", out_valid, 1);
    check("stall_first_operand", operand, 3);
    check("stall_first_in_ready", in_ready, 1);
    instr = 8'h27;
    step();
    check("stall_skid_in_ready", in_ready, 0);
    check("stall_hold_operand", operand, 3);
    instr = 8'h3F;
    step();
    check("stall_blocked_in_ready", in_ready, 0);
    check("stall_hold_ctrl", ctrl, 6'b000010);
    check("stall_hold_operand2", operand, 3);
    out_ready = 1'b1;
    step();
    check("drain_second_operand", operand, 7);
    check("drain_second_ctrl", ctrl, 6'b000100);
    check("drain_in_ready", in_ready, 1);
    step();
    check("drain_third_ctrl", ctrl, 6'b001000);
    check("drain_third_operand", operand, 4'hF);
    in_valid = 1'b0;
    step();
    check("drain_empty", out_valid, 0);

    // illegal opcode
    in_valid = 1'b1; instr = 8'hA5;
    step();
    in_valid = 1'b0;
`ifdef DECODE_STAGE_ILLEGAL_TRAP_EN
    check("trap_set", trap, 1);
    check("trap_no_forward", out_valid, 0);
    check("trap_in_ready", in_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("trap_survives_flush", trap, 1);
    check("trap_flush_in_ready", in_ready, 0);
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    check("trap_cleared", trap, 0);
    check("trap_clr_in_ready_late", in_ready, 0);
    step();
    check("trap_in_ready_back", in_ready, 1);
    check("trap_nothing_out", out_valid, 0);
`else
    check("illegal_valid", out_valid, 1);
    check("illegal_ctrl", ctrl, 0);
    check("illegal_flag", illegal, 1);
    check("illegal_operand", operand, 5);
    check("illegal_no_trap", trap, 0);
    step();
    check("illegal_drained", out_valid, 0);
`endif

    // flush with both entries full and an instruction on offer
    out_ready = 1'b0; in_valid = 1'b1; instr = 8'h11;
    step();
    instr = 8'h22;
    step();
    check("flush_pre_full", in_ready, 0);
    instr = 8'h33; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_count", dec_count, exp_cnt);
    out_ready = 1'b1;
    step();
    check("flush_nothing_out", out_valid, 0);

    // reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; instr = 8'h44;
    step();
    instr = 8'h55;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_dec_count", dec_count, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    step();
    check("midrst_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("midrst_dropped", out_valid, 0);

    // counter wrap
    in_valid = 1'b1; instr = 8'h00;
    for (int i = 0; i < 65535; i++) step();
    in_valid = 1'b0;
    step();
    check("wrap_max", dec_count, 16'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("wrap_zero", dec_count, 16'h0000);
    check("wrap_empty", out_valid, 0);

    // final report
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
